// File: rtl/block_fetch_if.sv
// block_fetch_if: request, memory-read and tile-output signals of block_fetch.
// Optional macro: BLOCK_FETCH_PAD_MASK_EN adds pad_mask (one bit per slot, 1 = zero-padded).
// Signals:
//   start/start_row/start_col : tile request and origin (master -> slave)
//   busy                      : block is reading or holding a tile (slave -> master)
//   mem_rd_en/mem_rd_addr     : memory read strobe and address (slave -> master)
//   mem_rd_data               : read data, one cycle after the strobe (master -> slave)
//   block_out/block_valid     : flat tile and its valid flag (slave -> master)
//   block_ready               : consumer accepts the tile (master -> slave)
interface block_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned J      = 2,
  parameter int unsigned K      = 2,
  parameter int unsigned ADDR_W = 16
);
  logic                  start;
  logic [9:0]            start_row;
  logic [9:0]            start_col;
  logic                  busy;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic [DATA_W-1:0]     mem_rd_data;
  logic [DATA_W*J*K-1:0] block_out;
  logic                  block_valid;
  logic                  block_ready;
`ifdef BLOCK_FETCH_PAD_MASK_EN
  logic [J*K-1:0]        pad_mask;

  modport slave (
    input  start, start_row, start_col, mem_rd_data, block_ready,
    output busy, mem_rd_en, mem_rd_addr, block_out, block_valid, pad_mask
  );
  modport master (
    output start, start_row, start_col, mem_rd_data, block_ready,
    input  busy, mem_rd_en, mem_rd_addr, block_out, block_valid, pad_mask
  );
`else
  modport slave (
    input  start, start_row, start_col, mem_rd_data, block_ready,
    output busy, mem_rd_en, mem_rd_addr, block_out, block_valid
  );
  modport master (
    output start, start_row, start_col, mem_rd_data, block_ready,
    input  busy, mem_rd_en, mem_rd_addr, block_out, block_valid
  );
`endif
endinterface

// File: rtl/block_fetch.sv
// block_fetch: reads a J x K tile at (start_row, start_col) from a row-major M x N matrix
// memory, one element per cycle, zero-padding elements outside the matrix, then presents the
// tile on a flat bus with a valid/ready handshake.
// Optional macro: BLOCK_FETCH_PAD_MASK_EN adds bus.pad_mask (slot e padded when bit e = 1).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : block_fetch_if.slave (request, memory read, tile output)
module block_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned J      = 2,
  parameter int unsigned K      = 2,
  parameter int unsigned M      = 4,
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  block_fetch_if.slave  bus
);

  localparam int unsigned NumEl = J * K;
  localparam int unsigned EW    = (NumEl > 1) ? $clog2(NumEl) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StValid} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [9:0]          r_r0;
  logic [9:0]          r_c0;
  logic [EW-1:0]       r_e;
  logic                r_pend;
  logic [EW-1:0]       r_pend_slot;
  logic [DATA_W-1:0]   r_slot [NumEl];
`ifdef BLOCK_FETCH_PAD_MASK_EN
  logic [NumEl-1:0]    r_pad;
`endif

  int unsigned         w_row;
  int unsigned         w_col;
  logic                w_in_range;
  logic                w_last;
  logic                w_load;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [DATA_W*NumEl-1:0] w_block;

  // Matrix coordinates of the current element.
  always_comb begin
    w_row      = 32'(r_r0) + 32'(r_e) / K;
    w_col      = 32'(r_c0) + 32'(r_e) % K;
    w_in_range = (w_row < M) && (w_col < N);
    w_last     = (32'(r_e) == NumEl - 1);
  end

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_load    = 1'b1;
          w_state_d = StRead;
        end
      end
      StRead: begin
        if (w_in_range) begin
          w_rd_en   = 1'b1;
          w_rd_addr = ADDR_W'(w_row * N + w_col);
        end
        if (w_last) w_state_d = StDrain;
      end
      StDrain: begin
        w_state_d = StValid;
      end
      StValid: begin
        if (bus.block_ready) begin
          // A start on the handshake edge chains straight into the next tile.
          if (bus.start) begin
            w_load    = 1'b1;
            w_state_d = StRead;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_r0        <= '0;
      r_c0        <= '0;
      r_e         <= '0;
      r_pend      <= 1'b0;
      r_pend_slot <= '0;
      for (int k = 0; k < int'(NumEl); k++) r_slot[k] <= '0;
`ifdef BLOCK_FETCH_PAD_MASK_EN
      r_pad       <= '0;
`endif
    end else begin
      r_state <= w_state_d;

      if (w_load) begin
        r_r0 <= bus.start_row;
        r_c0 <= bus.start_col;
        r_e  <= '0;
      end else if (r_state == StRead) begin
        r_e  <= r_e + EW'(1);
      end

      // Data of the read issued last cycle lands now; its slot differs from r_e.
      if (r_pend) r_slot[r_pend_slot] <= bus.mem_rd_data;

      if (r_state == StRead) begin
        r_pend      <= w_in_range;
        r_pend_slot <= r_e;
        if (!w_in_range) r_slot[r_e] <= '0;
`ifdef BLOCK_FETCH_PAD_MASK_EN
        r_pad[r_e]  <= ~w_in_range;
`endif
      end else begin
        r_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_block = '0;
    for (int k = 0; k < int'(NumEl); k++) w_block[k*DATA_W +: DATA_W] = r_slot[k];
  end

  assign bus.busy        = (r_state != StIdle);
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_addr = w_rd_addr;
  assign bus.block_out   = w_block;
  assign bus.block_valid = (r_state == StValid);
`ifdef BLOCK_FETCH_PAD_MASK_EN
  assign bus.pad_mask    = r_pad;
`endif

endmodule

// File: tb/tb_block_fetch.sv
// tb_block_fetch: directed self-checking bench for block_fetch with default geometry
// (M = N = 4, J = K = 2) and a memory model holding mem[a] = a + 1.
module tb_block_fetch;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned J      = 2;
  localparam int unsigned K      = 2;
  localparam int unsigned M      = 4;
  localparam int unsigned N      = 4;
  localparam int unsigned ADDR_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  block_fetch_if #(.DATA_W(DATA_W), .J(J), .K(K), .ADDR_W(ADDR_W)) bus_if ();

  block_fetch #(
    .DATA_W(DATA_W), .J(J), .K(K), .M(M), .N(N), .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // Memory model: data one cycle after the strobe; junk otherwise to expose bad captures.
  always @(posedge clk) begin
    bus_if.mem_rd_data <= bus_if.mem_rd_en ? (32'(bus_if.mem_rd_addr) + 32'd1) : 32'hDEADBEEF;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] blk(input int e0, input int e1, input int e2, input int e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int row, input int col);
    bus_if.start     = 1'b1;
    bus_if.start_row = 10'(row);
    bus_if.start_col = 10'(col);
    tick();
    bus_if.start     = 1'b0;
  endtask

  // Checks the four READ cycles; address must be 0 whenever the strobe is low.
  task automatic watch_reads(input string tag, input logic [3:0] en,
                             input int a0, input int a1, input int a2, input int a3);
    int a [4];
    a = '{a0, a1, a2, a3};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s rd_en[%0d]", tag, k), bus_if.mem_rd_en, en[k]);
      check($sformatf("%s addr[%0d]", tag, k), bus_if.mem_rd_addr, en[k] ? 16'(a[k]) : 16'd0);
      check($sformatf("%s busy[%0d]", tag, k), bus_if.busy, 1'b1);
      check($sformatf("%s valid_lo[%0d]", tag, k), bus_if.block_valid, 1'b0);
      tick();
    end
  endtask

  // From DRAIN: valid still low, then high with the expected tile after one more edge.
  task automatic finish_tile(input string tag, input logic [127:0] exp_blk);
    check({tag, " drain valid"}, bus_if.block_valid, 1'b0);
    check({tag, " drain rd_en"}, bus_if.mem_rd_en, 1'b0);
    tick();
    check({tag, " valid"}, bus_if.block_valid, 1'b1);
    check({tag, " block"}, bus_if.block_out, exp_blk);
  endtask

  initial begin
    bus_if.start       = 1'b0;
    bus_if.start_row   = '0;
    bus_if.start_col   = '0;
    bus_if.block_ready = 1'b1;
    #12;
    check("rst busy", bus_if.busy, 1'b0);
    check("rst rd_en", bus_if.mem_rd_en, 1'b0);
    check("rst addr", bus_if.mem_rd_addr, 16'd0);
    check("rst block", bus_if.block_out, 128'd0);
    check("rst valid", bus_if.block_valid, 1'b0);
`ifdef BLOCK_FETCH_PAD_MASK_EN
    check("rst pad", bus_if.pad_mask, 4'b0000);
`endif
    #11 rst_n = 1'b1;
    tick();

    // Tile (0,0), ready held high.
    do_start(0, 0);
    watch_reads("t1", 4'b1111, 0, 1, 4, 5);
    finish_tile("t1", blk(1, 2, 5, 6));
`ifdef BLOCK_FETCH_PAD_MASK_EN
    check("t1 pad", bus_if.pad_mask, 4'b0000);
`endif
    tick();
    check("t1 valid one cycle", bus_if.block_valid, 1'b0);
    check("t1 idle busy", bus_if.busy, 1'b0);

    // Corner tile (3,3): one read, three padded slots.
    do_start(3, 3);
    watch_reads("t2", 4'b0001, 15, 0, 0, 0);
    finish_tile("t2", blk(16, 0, 0, 0));
`ifdef BLOCK_FETCH_PAD_MASK_EN
    check("t2 pad", bus_if.pad_mask, 4'b1110);
`endif
    tick();

    // Tile (1,1) held under back-pressure; a start pulse in VALID without handshake is ignored.
    bus_if.block_ready = 1'b0;
    do_start(1, 1);
    watch_reads("t3", 4'b1111, 5, 6, 9, 10);
    finish_tile("t3", blk(6, 7, 10, 11));
    for (int c = 0; c < 10; c++) begin
      bus_if.start = (c == 6);
      check($sformatf("t3 hold valid[%0d]", c), bus_if.block_valid, 1'b1);
      check($sformatf("t3 hold block[%0d]", c), bus_if.block_out, blk(6, 7, 10, 11));
      check($sformatf("t3 hold rd_en[%0d]", c), bus_if.mem_rd_en, 1'b0);
      tick();
    end
    bus_if.start = 1'b0;
    bus_if.block_ready = 1'b1;
    tick();
    check("t3 idle valid", bus_if.block_valid, 1'b0);
    check("t3 idle busy", bus_if.busy, 1'b0);
    tick();
    check("t3 still idle", bus_if.busy, 1'b0);

    // Back-to-back: (0,0) accepted with start (0,2) on the same edge.
    do_start(0, 0);
    watch_reads("t4a", 4'b1111, 0, 1, 4, 5);
    finish_tile("t4a", blk(1, 2, 5, 6));
    bus_if.start     = 1'b1;
    bus_if.start_row = 10'd0;
    bus_if.start_col = 10'd2;
    tick();
    bus_if.start     = 1'b0;
    watch_reads("t4b", 4'b1111, 2, 3, 6, 7);
    finish_tile("t4b", blk(3, 4, 7, 8));
    tick();

    // Asynchronous reset in the middle of READ of (2,2).
    do_start(2, 2);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5 rst busy", bus_if.busy, 1'b0);
    check("t5 rst rd_en", bus_if.mem_rd_en, 1'b0);
    check("t5 rst addr", bus_if.mem_rd_addr, 16'd0);
    check("t5 rst block", bus_if.block_out, 128'd0);
    check("t5 rst valid", bus_if.block_valid, 1'b0);
`ifdef BLOCK_FETCH_PAD_MASK_EN
    check("t5 rst pad", bus_if.pad_mask, 4'b0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_start(0, 0);
    watch_reads("t5", 4'b1111, 0, 1, 4, 5);
    finish_tile("t5", blk(1, 2, 5, 6));
    tick();

    // Origin fully outside the matrix: no reads, zero tile, same latency.
    do_start(7, 0);
    watch_reads("t6", 4'b0000, 0, 0, 0, 0);
    finish_tile("t6", blk(0, 0, 0, 0));
`ifdef BLOCK_FETCH_PAD_MASK_EN
    check("t6 pad", bus_if.pad_mask, 4'b1111);
`endif
    tick();
    check("t6 idle busy", bus_if.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
